instr_fetch: RTL and testbench

//  Instruction fetch sequencer: the reading side of Program_Mem. Drives pc, samples
//  the combinational ir, resolves GOTO internally and hands every other instruction
//  to the execute stage over a valid/ready handshake. Sits between Program_Mem and
//  the decode/execute unit of the Jac1-8 core.

---
 rtl/instr_fetch.sv | 97 +++++++++
 tb/tb_instr_fetch.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: reading side of Program_Mem for the Jac1-8 core.
// Drives pc and samples the same-cycle ir. GOTO is resolved locally;
// every other word goes to the execute stage over instr_valid/exec_ready.
module instr_fetch #(
    parameter int unsigned PC_WIDTH = 8,
    parameter int unsigned IRWidth  = 16,
    parameter int unsigned CMD_CNT  = 64,
    parameter logic [3:0]  OP_GOTO  = 4'b1000
) (
    input  logic                clk,
    input  logic                res_n,
    output logic [PC_WIDTH-1:0] pc,
    input  logic [IRWidth-1:0]  ir,
    input  logic                halt,
    output logic [IRWidth-1:0]  instr,
    output logic [PC_WIDTH-1:0] instr_pc,
    output logic                instr_valid,
    input  logic                exec_ready,
    output logic                addr_err
);

    // state | meaning
    // BOOT  | first cycle after reset; Program_Mem image settling, no capture
    // FETCH | nothing pending; capture the word at pc every cycle
    // ISSUE | instruction pending on instr/instr_pc until exec_ready
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;

    localparam logic [PC_WIDTH:0]   CMD_CNT_W = (PC_WIDTH + 1)'(CMD_CNT);
    localparam logic [PC_WIDTH-1:0] PC_LAST   = PC_WIDTH'(CMD_CNT - 1);
    localparam logic [PC_WIDTH-1:0] PC_ONE    = PC_WIDTH'(1);

    state_t              state;
    logic                is_goto;
    logic                target_ok;
    logic                take_slot;
    logic [PC_WIDTH-1:0] target;
    logic [PC_WIDTH-1:0] pc_seq;

    // Decode the word at pc, its branch target and the sequential successor.
    // take_slot: the output register is free this edge (nothing pending, or
    // the pending instruction is being accepted), so a capture may happen.
    always_comb begin
        is_goto   = (ir[IRWidth-1 -: 4] == OP_GOTO);
        target    = ir[PC_WIDTH-1:0];
        target_ok = ({1'b0, target} < CMD_CNT_W);
        pc_seq    = (pc == PC_LAST) ? '0 : pc + PC_ONE;
        take_slot = (state == FETCH) || ((state == ISSUE) && exec_ready);
    end

    // Fetch sequencer: boot delay, GOTO resolution, issue and hold.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state       <= BOOT;
            pc          <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            addr_err    <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state <= FETCH;
                end
                FETCH, ISSUE: begin
                    if (take_slot) begin
                        if (halt) begin
                            instr_valid <= 1'b0;
                            state       <= FETCH;
                        end else if (is_goto) begin
                            // out-of-range targets restart at 0 and flag it
                            pc          <= target_ok ? target : '0;
                            if (!target_ok) begin
                                addr_err <= 1'b1;
                            end
                            instr_valid <= 1'b0;
                            state       <= FETCH;
                        end else begin
                            instr       <= ir;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                            pc          <= pc_seq;
                            state       <= ISSUE;
                        end
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios plus randomized program/handshake
// traffic against a behavioural fetch model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        res_n = 1'b0;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic        halt = 1'b0;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        exec_ready = 1'b0;
    logic        addr_err;

    logic [15:0] mem [0:255];

    int n_chk  = 0;
    int n_pass = 0;

    // behavioural model of the fetch unit
    int          m_pc;
    bit          m_valid;
    logic [15:0] m_instr;
    int          m_ipc;
    bit          m_err;
    bit          m_boot;

    assign ir = mem[pc];

    always #5 clk = ~clk;

    instr_fetch #(
        .PC_WIDTH(8),
        .IRWidth(16),
        .CMD_CNT(64),
        .OP_GOTO(4'b1000)
    ) dut (
        .clk(clk),
        .res_n(res_n),
        .pc(pc),
        .ir(ir),
        .halt(halt),
        .instr(instr),
        .instr_pc(instr_pc),
        .instr_valid(instr_valid),
        .exec_ready(exec_ready),
        .addr_err(addr_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_pc = 0; m_valid = 0; m_instr = '0; m_ipc = 0; m_err = 0; m_boot = 1;
    endtask

    // One clock of the fetch rules: the slot is free when nothing is
    // pending or the pending instruction is taken this cycle.
    task automatic model_step(input bit h, input bit r);
        logic [15:0] w;
        int          t;
        if (m_boot) begin
            m_boot = 0;
        end else if (!m_valid || r) begin
            if (h) begin
                m_valid = 0;
            end else begin
                w = mem[m_pc];
                if (w[15:12] == 4'h8) begin
                    t = int'(w[7:0]);
                    if (t < 64) m_pc = t;
                    else begin m_pc = 0; m_err = 1; end
                    m_valid = 0;
                end else begin
                    m_instr = w;
                    m_ipc   = m_pc;
                    m_valid = 1;
                    m_pc    = (m_pc + 1) % 64;
                end
            end
        end
    endtask

    task automatic cmp_all(input string tag);
        chk({tag, ".pc"},       32'(pc),          32'(m_pc));
        chk({tag, ".valid"},    32'(instr_valid), 32'(m_valid));
        chk({tag, ".instr"},    32'(instr),       32'(m_instr));
        chk({tag, ".instr_pc"}, 32'(instr_pc),    32'(m_ipc));
        chk({tag, ".addr_err"}, 32'(addr_err),    32'(m_err));
    endtask

    // inputs change at posedge+1; outputs sampled at the following posedge+1
    task automatic cyc(input string tag, input bit h, input bit r);
        halt = h;
        exec_ready = r;
        @(posedge clk);
        model_step(h, r);
        #1;
        cmp_all(tag);
    endtask

    // asynchronous reset away from any clock edge, released on a negedge
    task automatic do_reset(input string tag);
        #2;
        res_n = 1'b0;
        model_reset();
        #1;
        chk({tag, ".rst_pc"},    32'(pc),          32'd0);
        chk({tag, ".rst_valid"}, 32'(instr_valid), 32'd0);
        cmp_all(tag);
        @(negedge clk);
        res_n = 1'b1;
    endtask

    task automatic fill_linear();
        for (int i = 0; i < 256; i++) mem[i] = 16'h2000 | 16'(i);
    endtask

    initial begin
        model_reset();
        fill_linear();

        // ---------------- reference program ----------------
        for (int i = 0; i < 10; i++) mem[i] = 16'h1000 + 16'(i);
        mem[3]  = 16'h0910;
        mem[10] = 16'h8008;
        #1;
        do_reset("ref");
        for (int c = 1; c <= 24; c++) begin
            bit ev;
            int eipc;
            cyc("ref", 1'b0, 1'b1);
            if (c == 1) begin ev = 0; eipc = 0; end
            else if (c <= 11) begin ev = 1; eipc = c - 2; end
            else begin
                ev = ((c - 12) % 3) != 0;
                eipc = (((c - 12) % 3) == 1) ? 8 : 9;
            end
            chk("ref.seq_valid", 32'(instr_valid), 32'(ev));
            if (ev) chk("ref.seq_pc", 32'(instr_pc), 32'(eipc));
        end
        chk("ref.no_err", 32'(addr_err), 32'd0);

        // ---------------- stall at instr_pc 3 ----------------
        do_reset("stall");
        for (int c = 1; c <= 5; c++) cyc("stall", 1'b0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            cyc("stall", 1'b0, 1'b0);
            chk("stall.instr", 32'(instr),    32'h0910);
            chk("stall.ipc",   32'(instr_pc), 32'd3);
            chk("stall.pc",    32'(pc),       32'd4);
        end
        cyc("stall", 1'b0, 1'b1);
        chk("stall.resume_ipc", 32'(instr_pc), 32'd4);

        // ---------------- GOTO and addr_err ----------------
        for (int i = 0; i < 256; i++) mem[i] = 16'h1234;
        mem[0] = 16'h8005;
        mem[5] = 16'h80FF;
        do_reset("goto");
        cyc("goto", 1'b0, 1'b1);
        cyc("goto", 1'b0, 1'b1);
        chk("goto.pc5",    32'(pc),          32'd5);
        chk("goto.bubble", 32'(instr_valid), 32'd0);
        cyc("goto", 1'b0, 1'b1);
        chk("goto.bad_pc",  32'(pc),       32'd0);
        chk("goto.bad_err", 32'(addr_err), 32'd1);
        mem[5] = 16'h8007;
        for (int c = 0; c < 3; c++) begin
            cyc("goto", 1'b0, 1'b1);
            chk("goto.err_sticky", 32'(addr_err), 32'd1);
        end
        chk("goto.ipc7", 32'(instr_pc), 32'd7);

        // ---------------- wrap 63 -> 0 ----------------
        fill_linear();
        do_reset("wrap");
        for (int c = 1; c <= 66; c++) begin
            cyc("wrap", 1'b0, 1'b1);
            if (c == 65) begin
                chk("wrap.ipc63", 32'(instr_pc), 32'd63);
                chk("wrap.pc0",   32'(pc),       32'd0);
            end
            if (c == 66) begin
                chk("wrap.ipc0",  32'(instr_pc), 32'd0);
                chk("wrap.instr", 32'(instr),    32'h2000);
            end
        end

        // ---------------- halt in FETCH at pc 6 ----------------
        mem[0] = 16'h8006;
        do_reset("halt");
        cyc("halt", 1'b0, 1'b1);
        cyc("halt", 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            cyc("halt", 1'b1, 1'b1);
            chk("halt.pc",    32'(pc),          32'd6);
            chk("halt.valid", 32'(instr_valid), 32'd0);
        end
        cyc("halt", 1'b0, 1'b1);
        chk("halt.issue_valid", 32'(instr_valid), 32'd1);
        chk("halt.issue_ipc",   32'(instr_pc),    32'd6);

        // ---------------- reset mid-operation at instr_pc 7 ----------------
        fill_linear();
        do_reset("mid");
        for (int c = 1; c <= 9; c++) cyc("mid", 1'b0, 1'b1);
        chk("mid.pre_valid", 32'(instr_valid), 32'd1);
        chk("mid.pre_ipc",   32'(instr_pc),    32'd7);
        do_reset("mid");
        cyc("mid", 1'b0, 1'b1);
        chk("mid.boot_valid", 32'(instr_valid), 32'd0);
        cyc("mid", 1'b0, 1'b1);
        chk("mid.first_valid", 32'(instr_valid), 32'd1);
        chk("mid.first_ipc",   32'(instr_pc),    32'd0);

        // ---------------- randomized program and handshake ----------------
        for (int i = 0; i < 256; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0)
                mem[i] = {4'h8, 4'($urandom), 8'($urandom_range(0, 70))};
            else begin
                if (op == 4'h8) op = 4'h9;
                mem[i] = {op, 12'($urandom)};
            end
        end
        do_reset("rnd");
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 99) < 2) do_reset("rnd");
            else cyc("rnd", $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0)
                mem[$urandom_range(0, 63)] = {4'h8, 4'h0, 8'($urandom_range(0, 80))};
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
